// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU.
// Single-cycle ops give their result one cycle after accept.
// MULU (shift-add) and DIVU (restoring) iterate for WIDTH cycles.
// While an op is in flight, in_ready stays low so the hazard unit can stall.
// Optional feature: define ALU_DIV_EN to build the divider.
// Without ALU_DIV_EN, op 10 is illegal.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sig_op,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             err,
  output logic             out_valid
);

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NOTB  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_MULU  = 4'd9;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef ALU_DIV_EN
    ,
    S_DIV  = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;    // MUL: {partial product, multiplier}
                                // DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opb_q;    // latched multiplicand / divisor
  logic               zero_pend;

  logic               accept;
  logic               start_mul, start_div;
  logic [WIDTH-1:0]   res_out, res_hi;
  logic               res_err;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  // Single-cycle result and multi-cycle start decode for the presented op.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
    res_out   = '0;
    res_hi    = '0;
    res_err   = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (sig_op)
      OP_PASSB: res_out = B;
      OP_ADD:   res_out = A + B;
      OP_SUB:   res_out = A - B;
      OP_AND:   res_out = A & B;
      OP_OR:    res_out = A | B;
      OP_NOTB:  res_out = ~B;
      OP_XOR:   res_out = A ^ B;
      OP_SLT:   res_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  res_out = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MULU:  start_mul = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU: begin
        if (B == '0) begin
          res_out = '1;
          res_hi  = A;
          res_err = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
`endif
      default:  res_err = 1'b1;
    endcase
  end

  // One iteration step of the multiplier or the divider.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    if (state_q == S_DIV) begin
      logic [WIDTH:0] div_shift, div_diff;
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (div_diff[WIDTH])   // shifted remainder < divisor: restore
        acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Next-state logic: leave IDLE on a multi-cycle accept, return on the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && start_mul)      state_d = S_MUL;
        else if (accept && start_div) state_d = S_IDLE;
`ifdef ALU_DIV_EN
        if (accept && start_div)      state_d = S_DIV;
`endif
      end
      default: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only seen at a clock edge.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      zero_pend <= 1'b0;
      out       <= '0;
      hi        <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        opb_q     <= B;
        zero_pend <= (A == B);
        if (start_mul || start_div) begin
          acc_q <= {{WIDTH{1'b0}}, A};
          cnt_q <= CNT_W'(WIDTH);
        end else begin
          out       <= res_out;
          hi        <= res_hi;
          err       <= res_err;
          zero      <= (A == B);
          out_valid <= 1'b1;
        end
      end else if (state_q != S_IDLE) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out       <= acc_step[WIDTH-1:0];
          hi        <= acc_step[2*WIDTH-1:WIDTH];
          err       <= 1'b0;
          zero      <= zero_pend;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
